ff_reg_arbiter: RTL and testbench

FF_REG_ARBITER -- requirements
Module: ff_reg_arbiter

---
 rtl/ff_reg_arbiter_pkg.sv | 27 ++
 rtl/dff_en_rn.sv | 27 ++
 rtl/ff_arb_defs.vh | 9 +
 rtl/ff_reg_arbiter.sv | 105 ++++++++++
 tb/tb_ff_reg_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ff_reg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ff_reg_arbiter_pkg
// Shared definitions for the two-requester register arbiter: FSM state
// encodings and the round-robin winner selection helper.
// ---------------------------------------------------------------------------
package ff_reg_arbiter_pkg;

`include "ff_arb_defs.vh"

    // Requester identifiers as stored in the last-served pointer.
    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;

    // Round-robin pick between two requesters. A lone request wins
    // outright; on a tie the requester that was not served last wins.
    // Only meaningful when at least one request bit is set.
    function automatic logic rr_winner(input logic [1:0] req, input logic last);
        logic win;
        if (req == 2'b11) begin
            win = ~last;
        end else begin
            win = req[1];
        end
        return win;
    endfunction

endpackage

// File: rtl/dff_en_rn.sv
// ---------------------------------------------------------------------------
// dff_en_rn
// Single D flip-flop with load enable and asynchronous active-low reset.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears o_q
//   i_en   - load enable; o_q holds when low
//   i_d    - data in
//   o_q    - registered data out
// ---------------------------------------------------------------------------
module dff_en_rn (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= 1'b0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/ff_arb_defs.vh
`ifndef FF_ARB_DEFS_VH
`define FF_ARB_DEFS_VH

// State encodings of the arbiter FSM.
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_LOAD = 2'd1;
localparam logic [1:0] ST_ACK  = 2'd2;

`endif

// File: rtl/ff_reg_arbiter.sv
// ---------------------------------------------------------------------------
// ff_reg_arbiter
// Two requesters share one WIDTH-bit register. A round-robin arbiter grants
// one requester, the register is loaded from the grantee's data bus, and a
// four-phase acknowledge completes the write.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   req_i    - write requests (bit 0 = R0, bit 1 = R1)
//   data0_i  - R0 write data
//   data1_i  - R1 write data
//   gnt_o    - one-hot grant, zero when idle
//   ack_o    - per-requester write-complete acknowledge
//   q_o      - shared register contents
//   busy_o   - high whenever the FSM is outside IDLE
// ---------------------------------------------------------------------------
module ff_reg_arbiter
    import ff_reg_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       ack_o,
    output logic [WIDTH-1:0] q_o,
    output logic             busy_o
);

    logic [1:0]       r_state;
    logic [1:0]       r_gnt;
    logic [1:0]       r_ack;
    logic             r_last;      // requester served most recently

    logic             w_winner;
    logic             w_load;
    logic             w_req_held;
    logic [WIDTH-1:0] w_wdata;

    assign w_winner   = rr_winner(req_i, r_last);
    assign w_load     = (r_state == ST_LOAD);
    // Only the granted requester's request can keep the ACK phase open.
    assign w_req_held = |(req_i & r_gnt);
    // Mux is steered by the registered grant, so the idle requester's bus
    // never reaches the register.
    assign w_wdata    = r_gnt[1] ? data1_i : data0_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'b00;
            r_ack   <= 2'b00;
            r_last  <= REQ_R1;     // so R0 wins the first tie
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_i) begin
                        r_gnt   <= w_winner ? 2'b10 : 2'b01;
                        r_last  <= w_winner;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Write completes even if the request already dropped;
                    // ACK then lasts exactly one cycle.
                    r_ack   <= r_gnt;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    if (!w_req_held) begin
                        r_ack   <= 2'b00;
                        r_gnt   <= 2'b00;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_ack   <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            dff_en_rn u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .i_en  (w_load),
                .i_d   (w_wdata[gi]),
                .o_q   (q_o[gi])
            );
        end
    endgenerate

    assign gnt_o  = r_gnt;
    assign ack_o  = r_ack;
    assign busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ff_reg_arbiter.sv
module tb_ff_reg_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             r0 = 1'b0;
    logic             r1 = 1'b0;
    logic [1:0]       req_i;
    logic [WIDTH-1:0] d0 = '0;
    logic [WIDTH-1:0] d1 = '0;
    logic [1:0]       gnt_o;
    logic [1:0]       ack_o;
    logic [WIDTH-1:0] q_o;
    logic             busy_o;

    assign req_i = {r1, r0};

    ff_reg_arbiter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .data0_i (d0),
        .data1_i (d1),
        .gnt_o   (gnt_o),
        .ack_o   (ack_o),
        .q_o     (q_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t sbq[$];
    int   last_id = 1;   // reference round-robin pointer: R1 after reset

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic void push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sbq.push_back(e);
    endfunction

    // Reference: one round with the requesters in pat raised together
    // while idle. A tie serves the requester not served last, then the other.
    function automatic void model_round(input logic [1:0] pat, input logic [7:0] a, input logic [7:0] b);
        int f;
        int o;
        if (pat == 2'b11) begin
            f = (last_id == 0) ? 1 : 0;
            o = 1 - f;
            push_exp(f, (f == 1) ? b : a);
            push_exp(o, (o == 1) ? b : a);
            last_id = o;
        end else begin
            f = pat[1] ? 1 : 0;
            push_exp(f, (f == 1) ? b : a);
            last_id = f;
        end
    endfunction

    task automatic wait_ack(input int k, input logic v);
        int n = 0;
        while (ack_o[k] !== v && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (ack_o[k] !== v) begin
            total++;
            bad++;
            $display("FAIL wait_ack%0d: got %0b want %0b", k, ack_o[k], v);
        end
    endtask

    // Four-phase requester behaviour for one round; called at a negedge.
    task automatic serve(input logic [1:0] pat, input logic [7:0] a, input logic [7:0] b);
        model_round(pat, a, b);
        fork
            begin
                if (pat[0]) begin
                    r0 = 1'b1;
                    d0 = a;
                    wait_ack(0, 1'b1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    r0 = 1'b0;
                    wait_ack(0, 1'b0);
                end
            end
            begin
                if (pat[1]) begin
                    r1 = 1'b1;
                    d1 = b;
                    wait_ack(1, 1'b1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    r1 = 1'b0;
                    wait_ack(1, 1'b0);
                end
            end
        join
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each acknowledge.
    initial begin
        logic [1:0] prev_ack;
        logic [1:0] want1h;
        exp_t       e;
        prev_ack = 2'b00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("exclusive", 32'({$onehot0(gnt_o), $onehot0(ack_o), ((ack_o & ~gnt_o) == 2'b00)}), 32'h7);
                chk("busy_vs_gnt", 32'(busy_o), 32'(|gnt_o));
                if (prev_ack == 2'b00 && ack_o != 2'b00) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ack: got %b want none", ack_o);
                    end else begin
                        e = sbq.pop_front();
                        want1h = (e.id == 1) ? 2'b10 : 2'b01;
                        chk("ack_id", 32'(ack_o), 32'(want1h));
                        chk("gnt_id", 32'(gnt_o), 32'(want1h));
                        chk("q_data", 32'(q_o), 32'(e.data));
                    end
                end
                prev_ack = ack_o;
            end else begin
                prev_ack = 2'b00;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fa [2][3];
        int         f;
        int         o;
        logic [1:0] pat;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_q", 32'(q_o), 32'h0);
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst_n = 1'b1;

        // Single request, exact cycle timing
        @(negedge clk);
        model_round(2'b01, 8'h3C, 8'h00);
        r0 = 1'b1;
        d0 = 8'h3C;
        @(posedge clk); #1;
        chk("single_gnt_e1", 32'(gnt_o), 32'h1);
        chk("single_ack_e1", 32'(ack_o), 32'h0);
        chk("single_busy_e1", 32'(busy_o), 32'h1);
        @(posedge clk); #1;
        chk("single_q_e2", 32'(q_o), 32'h3C);
        chk("single_ack_e2", 32'(ack_o), 32'h1);
        @(negedge clk);
        r0 = 1'b0;
        @(posedge clk); #1;
        chk("single_ack_drop", 32'(ack_o), 32'h0);
        chk("single_busy_drop", 32'(busy_o), 32'h0);
        chk("single_gnt_drop", 32'(gnt_o), 32'h0);

        // Reset asserted mid-ACK
        @(negedge clk);
        model_round(2'b01, 8'hA5, 8'h00);
        r0 = 1'b1;
        d0 = 8'hA5;
        wait_ack(0, 1'b1);
        chk("preRst_q", 32'(q_o), 32'hA5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        r0 = 1'b0;
        #1;
        chk("midRst_q", 32'(q_o), 32'h0);
        chk("midRst_gnt", 32'(gnt_o), 32'h0);
        chk("midRst_ack", 32'(ack_o), 32'h0);
        chk("midRst_busy", 32'(busy_o), 32'h0);
        last_id = 1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);

        // Tie right after reset: R0 first, then R1 without re-assertion
        serve(2'b11, 8'h11, 8'h22);
        chk("tie_final_q", 32'(q_o), 32'h22);

        // R1 drops its request during LOAD
        model_round(2'b10, 8'h00, 8'h5A);
        r1 = 1'b1;
        d1 = 8'h5A;
        @(posedge clk); #1;
        chk("viol_gnt", 32'(gnt_o), 32'h2);
        @(negedge clk);
        r1 = 1'b0;
        @(posedge clk); #1;
        chk("viol_ack_on", 32'(ack_o), 32'h2);
        chk("viol_q", 32'(q_o), 32'h5A);
        @(posedge clk); #1;
        chk("viol_ack_off", 32'(ack_o), 32'h0);
        chk("viol_idle", 32'(busy_o), 32'h0);
        @(negedge clk);

        // R1 data bus toggles while R0 is served
        fork
            serve(2'b01, 8'hC3, 8'h00);
            begin
                repeat (8) begin
                    @(negedge clk);
                    d1 = ~d1;
                end
            end
        join
        chk("iso_q", 32'(q_o), 32'hC3);
        @(negedge clk);

        // Both requesters keep requesting: grants alternate
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++)
                fa[k][i] = 8'($urandom);
        f = (last_id == 0) ? 1 : 0;
        o = 1 - f;
        for (int i = 0; i < 3; i++) begin
            push_exp(f, fa[f][i]);
            push_exp(o, fa[o][i]);
        end
        last_id = o;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    r0 = 1'b1;
                    d0 = fa[0][i];
                    wait_ack(0, 1'b1);
                    @(negedge clk);
                    r0 = 1'b0;
                    wait_ack(0, 1'b0);
                end
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    r1 = 1'b1;
                    d1 = fa[1][j];
                    wait_ack(1, 1'b1);
                    @(negedge clk);
                    r1 = 1'b0;
                    wait_ack(1, 1'b0);
                end
            end
        join
        @(negedge clk);

        // Randomised rounds
        repeat (30) begin
            pat = 2'($urandom_range(1, 3));
            serve(pat, 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
